wrr_arbiter: RTL

Parametrised weighted round-robin arbiter for the multi-bank memory request path, and the next generation of the single-cycle round-robin arbiter. Each requester holds a registered, one-hot grant for up to a per-requester credit of accepted beats, or until it drops its request. Rotation then passes to the next requester after the holder. Back-to-back handover has no idle cycle, which lets a bank port sustain bursts while bounding every requester's wait.

---
 rtl/wrr_arbiter_pkg.sv | 26 ++
 rtl/wrr_arbiter_rr_pick.sv | 40 ++++
 rtl/wrr_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/wrr_arbiter_pkg.sv
// wrr_arbiter_pkg: shared types and helpers for the weighted round-robin
// arbiter.
//   state_t        - arbiter FSM state (IDLE, BUSY)
//   onehot_to_idx  - binary index of the set bit in a one-hot vector (N <= 32)
//   weight_or_one  - burst credit for a weight field; a weight of 0 maps to 1
package wrr_arbiter_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

  function automatic logic [31:0] weight_or_one(input logic [31:0] w);
    return (w == '0) ? 32'd1 : w;
  endfunction

endpackage

// File: rtl/wrr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin pick.
// Winner is the first set req bit at index >= ptr, wrapping modulo N.
//   req    [N]     - candidate requests
//   ptr    [IDX_W] - round-robin start index (always < N)
//   onehot [N]     - one-hot winner, zero when no request
//   idx    [IDX_W] - binary index of the winner
//   any            - at least one request present
module rr_pick
  import wrr_arbiter_pkg::*;
#(
  parameter int unsigned N     = 5,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int unsigned j;
  logic        found;

  always_comb begin
    onehot = '0;
    found  = 1'b0;
    j      = 0;
    for (int unsigned i = 0; i < N; i++) begin
      j = (32'(ptr) + i) % N;
      if (req[j] && !found) begin
        onehot[j] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  assign idx = IDX_W'(onehot_to_idx(32'(onehot)));
  assign any = |req;

endmodule

// File: rtl/wrr_arbiter.sv
// wrr_arbiter: weighted round-robin arbiter with registered one-hot grant.
// A holder keeps the grant for up to weight[h] accepted beats (0 counts as 1)
// or until it drops its request; the next holder is granted on the same edge
// as the release, so handover has no idle cycle.
//   clk, rst     - clock, asynchronous active-high reset
//   req [N]      - level requests
//   weight [N*W_BITS] - per-requester burst credit, field i at [i*W_BITS +: W_BITS]
//   prio [N]     - high-priority class mask (only with WRR_ARBITER_PRIO_EN)
//   gnt_ack      - downstream accepted one beat from the holder
//   grant [N]    - registered one-hot grant
//   grant_idx    - binary index of holder, valid with grant_valid
//   grant_valid  - OR of grant
// Optional feature macro: WRR_ARBITER_PRIO_EN (priority class filter).
module wrr_arbiter
  import wrr_arbiter_pkg::*;
#(
  parameter  int unsigned N      = 5,
  parameter  int unsigned W_BITS = 4,
  localparam int unsigned IDX_W  = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req,
  input  logic [N*W_BITS-1:0]   weight,
`ifdef WRR_ARBITER_PRIO_EN
  input  logic [N-1:0]          prio,
`endif
  input  logic                  gnt_ack,
  output logic [N-1:0]          grant,
  output logic [IDX_W-1:0]      grant_idx,
  output logic                  grant_valid
);

  state_t             state_q, state_d;
  logic [N-1:0]       grant_q, grant_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [W_BITS-1:0]  credit_q, credit_d;

  logic               held, release_now;
  logic [IDX_W-1:0]   nxt_ptr, pick_ptr, pick_idx;
  logic [N-1:0]       pick_req, pick_oh;
  logic               pick_any;
  logic [W_BITS-1:0]  raw_weight, load_credit;

  assign held        = |(req & grant_q);
  assign release_now = (state_q == BUSY) &&
                       (!held || (gnt_ack && credit_q == W_BITS'(1)));
  assign nxt_ptr     = (idx_q == IDX_W'(N-1)) ? '0 : idx_q + IDX_W'(1);
  // Re-arbitration on release must already see the advanced pointer.
  assign pick_ptr    = release_now ? nxt_ptr : ptr_q;

`ifdef WRR_ARBITER_PRIO_EN
  logic [N-1:0] hi_req;
  assign hi_req   = req & prio;
  assign pick_req = (hi_req != '0) ? hi_req : req;
`else
  assign pick_req = req;
`endif

  rr_pick #(.N(N), .IDX_W(IDX_W)) u_pick (
    .req    (pick_req),
    .ptr    (pick_ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    raw_weight = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (pick_oh[i]) raw_weight = weight[i*W_BITS +: W_BITS];
    end
    load_credit = W_BITS'(weight_or_one(32'(raw_weight)));
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    idx_d    = idx_q;
    ptr_d    = ptr_q;
    credit_d = credit_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d  = BUSY;
          grant_d  = pick_oh;
          idx_d    = pick_idx;
          credit_d = load_credit;
        end
      end
      BUSY: begin
        if (release_now) begin
          ptr_d = nxt_ptr;
          if (pick_any) begin
            grant_d  = pick_oh;
            idx_d    = pick_idx;
            credit_d = load_credit;
          end else begin
            state_d  = IDLE;
            grant_d  = '0;
            idx_d    = '0;
            credit_d = '0;
          end
        end else if (gnt_ack) begin
          credit_d = credit_q - W_BITS'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      idx_q    <= '0;
      ptr_q    <= '0;
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      idx_q    <= idx_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = idx_q;
  assign grant_valid = |grant_q;

endmodule
